multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, the unified instruction/data memory port, the instruction register, the PC and the register file across cycles.
- Drives ALUOp into the existing ALU decoder, which turns it into ALUControl using funct3/funct7.
- Adds a memory-ready handshake so that slow memory stalls the core cleanly.

---
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core, with a memory-ready stall handshake.
// Optional trap on unknown opcodes when ILLEGAL_OP_TRAP_EN is defined (adds TRAP state and illegal_op).
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         imm_src,
    output logic               reg_write,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [STATE_W-1:0] state_dbg
);

    // state     | meaning
    // ----------+---------------------------------------------------------
    // FETCH     | read instruction at PC, PC <= PC+4 when memory is ready
    // DECODE    | read register file, ALUOut <= OldPC + imm (branch target)
    // MEMADR    | ALUOut <= rs1 + imm (load/store address)
    // MEMREAD   | read data memory at ALUOut, wait for mem_ready
    // MEMWB     | rd <= Data
    // MEMWRITE  | write rs2 to memory at ALUOut, wait for mem_ready
    // EXECR     | ALUOut <= rs1 op rs2
    // EXECI     | ALUOut <= rs1 op imm
    // ALUWB     | rd <= ALUOut
    // BEQ       | compare rs1/rs2, PC <= branch target when equal
    // JAL       | PC <= target, ALUOut <= OldPC + 4 (link value)
    // TRAP      | unknown opcode, frozen until reset (optional)

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        s_fetch    = STATE_W'(0),
        s_decode   = STATE_W'(1),
        s_memadr   = STATE_W'(2),
        s_memread  = STATE_W'(3),
        s_memwb    = STATE_W'(4),
        s_memwrite = STATE_W'(5),
        s_execr    = STATE_W'(6),
        s_execi    = STATE_W'(7),
        s_aluwb    = STATE_W'(8),
        s_beq      = STATE_W'(9),
        s_jal      = STATE_W'(10)
`ifdef ILLEGAL_OP_TRAP_EN
        , s_trap   = STATE_W'(11)
`endif
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t cur;

    logic pcw_raw;
    logic mw_raw;
    logic irw_raw;
    logic rw_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= s_fetch;
        end else begin
            state <= state_nxt;
        end
    end

    // While reset is held the outputs show FETCH, even before the first clock edge.
    always_comb begin
        cur        = rst_n ? state : s_fetch;
        state_nxt  = s_fetch;
        pcw_raw    = 1'b0;
        mw_raw     = 1'b0;
        irw_raw    = 1'b0;
        rw_raw     = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_op = 1'b0;
`endif
        case (cur)
            s_fetch: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                irw_raw    = mem_ready;
                pcw_raw    = mem_ready;
                state_nxt  = mem_ready ? s_decode : s_fetch;
            end
            s_decode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_nxt = s_memadr;
                    OP_R:         state_nxt = s_execr;
                    OP_I:         state_nxt = s_execi;
                    OP_BEQ:       state_nxt = s_beq;
                    OP_JAL:       state_nxt = s_jal;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      state_nxt = s_trap;
`else
                    default:      state_nxt = s_fetch;
`endif
                endcase
            end
            s_memadr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_SW) begin
                    state_nxt = s_memwrite;
                end else if (op == OP_LW) begin
                    state_nxt = s_memread;
                end else begin
                    state_nxt = s_fetch;
                end
            end
            s_memread: begin
                adr_src   = 1'b1;
                state_nxt = mem_ready ? s_memwb : s_memread;
            end
            s_memwb: begin
                result_src = 2'b01;
                rw_raw     = 1'b1;
                state_nxt  = s_fetch;
            end
            s_memwrite: begin
                adr_src   = 1'b1;
                mw_raw    = 1'b1;
                state_nxt = mem_ready ? s_fetch : s_memwrite;
            end
            s_execr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_nxt = s_aluwb;
            end
            s_execi: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = s_aluwb;
            end
            s_aluwb: begin
                rw_raw    = 1'b1;
                state_nxt = s_fetch;
            end
            s_beq: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pcw_raw   = zero;
                state_nxt = s_fetch;
            end
            s_jal: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pcw_raw   = 1'b1;
                state_nxt = s_aluwb;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            s_trap: begin
                illegal_op = 1'b1;
                state_nxt  = s_trap;
            end
`endif
            default: begin
                state_nxt = s_fetch;
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Architectural write strobes are killed outright while reset is asserted.
    assign pc_write  = pcw_raw & rst_n;
    assign mem_write = mw_raw  & rst_n;
    assign ir_write  = irw_raw & rst_n;
    assign reg_write = rw_raw  & rst_n;
    assign state_dbg = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: an instruction-level model expands each
// instruction (opcode, stall counts, zero flag) into the expected per-cycle states and outputs.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] state_dbg;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] op;
        logic       mr;
        logic       z;
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, ao;
    } cyc_t;

    cyc_t q[$];

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .reg_write(reg_write),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [14:0] expv(input cyc_t c);
        return {c.pcw, c.adr, c.mw, c.irw, c.rs, c.sa, c.sb, c.ao, c.rw, imm_of(c.op)};
    endfunction

    function automatic logic [14:0] act();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                alu_op, reg_write, imm_src};
    endfunction

    function automatic cyc_t mk(input logic [6:0] o, input logic [3:0] st,
                                input logic pcw, input logic adr, input logic mw,
                                input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [1:0] ao, input logic rw);
        cyc_t c;
        c.op = o; c.st = st; c.pcw = pcw; c.adr = adr; c.mw = mw; c.irw = irw;
        c.rs = rs; c.sa = sa; c.sb = sb; c.ao = ao; c.rw = rw;
        c.mr = 1'($urandom_range(0, 1));
        c.z  = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // Expand one instruction into expected cycles: fs fetch stalls, ms memory stalls.
    task automatic build(input logic [6:0] o, input int fs, input int ms, input logic z,
                         input int trap_len);
        cyc_t c;
        for (int i = 0; i < fs; i++) begin
            c = mk(o, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0); c.mr = 0; q.push_back(c);
        end
        c = mk(o, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0); c.mr = 1; q.push_back(c);
        q.push_back(mk(o, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0));
        case (o)
            OP_LW: begin
                q.push_back(mk(o, 2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0));
                for (int i = 0; i <= ms; i++) begin
                    c = mk(o, 3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
                    c.mr = (i == ms); q.push_back(c);
                end
                q.push_back(mk(o, 4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1));
            end
            OP_SW: begin
                q.push_back(mk(o, 2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0));
                for (int i = 0; i <= ms; i++) begin
                    c = mk(o, 5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
                    c.mr = (i == ms); q.push_back(c);
                end
            end
            OP_R: begin
                q.push_back(mk(o, 6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0));
                q.push_back(mk(o, 8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1));
            end
            OP_I: begin
                q.push_back(mk(o, 7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0));
                q.push_back(mk(o, 8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1));
            end
            OP_BEQ: begin
                c = mk(o, 9, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0); c.z = z; q.push_back(c);
            end
            OP_JAL: begin
                q.push_back(mk(o, 10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0));
                q.push_back(mk(o, 8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1));
            end
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                for (int i = 0; i < trap_len; i++)
                    q.push_back(mk(o, 11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
`endif
            end
        endcase
    endtask

    task automatic drive(input cyc_t c);
        op = c.op; mem_ready = c.mr; zero = c.z;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        op = OP_I; mem_ready = 1'b1; zero = 1'b0; rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (state_dbg !== 4'd0) begin
                bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg);
            end
            total++;
            if (act() !== {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00}) begin
                bad++; $display("FAIL reset_outs got=%b", act());
            end
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        build(OP_I, 0, 0, 1'b0, 0);
        foreach (q[i]) begin
            drive(q[i]);
            total++;
            if (state_dbg !== q[i].st) begin
                bad++; $display("FAIL post_reset cyc%0d state got=%0d exp=%0d", i, state_dbg, q[i].st);
            end
            total++;
            if (act() !== expv(q[i])) begin
                bad++; $display("FAIL post_reset cyc%0d outs got=%b exp=%b", i, act(), expv(q[i]));
            end
            advance();
        end
        q.delete();
    endtask

    task automatic test_rtype();
        build(OP_R, 0, 0, 1'b0, 0);
        build(OP_R, 2, 0, 1'b1, 0);
        foreach (q[i]) begin
            drive(q[i]);
            total++;
            if (state_dbg !== q[i].st) begin
                bad++; $display("FAIL rtype cyc%0d state got=%0d exp=%0d", i, state_dbg, q[i].st);
            end
            total++;
            if (act() !== expv(q[i])) begin
                bad++; $display("FAIL rtype cyc%0d outs got=%b exp=%b", i, act(), expv(q[i]));
            end
            advance();
        end
        q.delete();
    endtask

    task automatic test_lw_stall();
        build(OP_LW, 0, 2, 1'b0, 0);
        build(OP_LW, 1, 0, 1'b0, 0);
        foreach (q[i]) begin
            drive(q[i]);
            total++;
            if (state_dbg !== q[i].st) begin
                bad++; $display("FAIL lw cyc%0d state got=%0d exp=%0d", i, state_dbg, q[i].st);
            end
            total++;
            if (act() !== expv(q[i])) begin
                bad++; $display("FAIL lw cyc%0d outs got=%b exp=%b", i, act(), expv(q[i]));
            end
            advance();
        end
        q.delete();
    endtask

    task automatic test_beq();
        build(OP_BEQ, 0, 0, 1'b1, 0);
        build(OP_BEQ, 0, 0, 1'b0, 0);
        foreach (q[i]) begin
            drive(q[i]);
            total++;
            if (state_dbg !== q[i].st) begin
                bad++; $display("FAIL beq cyc%0d state got=%0d exp=%0d", i, state_dbg, q[i].st);
            end
            total++;
            if (act() !== expv(q[i])) begin
                bad++; $display("FAIL beq cyc%0d outs got=%b exp=%b", i, act(), expv(q[i]));
            end
            advance();
        end
        q.delete();
    endtask

    task automatic test_sw_jal();
        build(OP_SW, 0, 0, 1'b0, 0);
        build(OP_SW, 0, 3, 1'b0, 0);
        build(OP_JAL, 0, 0, 1'b0, 0);
        foreach (q[i]) begin
            drive(q[i]);
            total++;
            if (state_dbg !== q[i].st) begin
                bad++; $display("FAIL sw_jal cyc%0d state got=%0d exp=%0d", i, state_dbg, q[i].st);
            end
            total++;
            if (act() !== expv(q[i])) begin
                bad++; $display("FAIL sw_jal cyc%0d outs got=%b exp=%b", i, act(), expv(q[i]));
            end
            advance();
        end
        q.delete();
    endtask

    task automatic test_illegal();
        build(OP_BAD, 0, 0, 1'b0, 10);
`ifndef ILLEGAL_OP_TRAP_EN
        build(OP_R, 0, 0, 1'b0, 0);
`endif
        foreach (q[i]) begin
            drive(q[i]);
            total++;
            if (state_dbg !== q[i].st) begin
                bad++; $display("FAIL illegal cyc%0d state got=%0d exp=%0d", i, state_dbg, q[i].st);
            end
            total++;
            if (act() !== expv(q[i])) begin
                bad++; $display("FAIL illegal cyc%0d outs got=%b exp=%b", i, act(), expv(q[i]));
            end
`ifdef ILLEGAL_OP_TRAP_EN
            total++;
            if (illegal_op !== (q[i].st == 4'd11)) begin
                bad++; $display("FAIL illegal_op cyc%0d got=%b exp=%b", i, illegal_op, q[i].st == 4'd11);
            end
`endif
            advance();
        end
        q.delete();
`ifdef ILLEGAL_OP_TRAP_EN
        rst_n = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        advance();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (state_dbg !== 4'd0 || illegal_op !== 1'b0) begin
            bad++; $display("FAIL trap_clear got state=%0d illegal_op=%b exp state=0 illegal_op=0",
                            state_dbg, illegal_op);
        end
        advance();
`endif
    endtask

    task automatic test_reset_mid();
        build(OP_SW, 0, 3, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(q[i]);
            total++;
            if (state_dbg !== q[i].st) begin
                bad++; $display("FAIL reset_mid cyc%0d state got=%0d exp=%0d", i, state_dbg, q[i].st);
            end
            total++;
            if (act() !== expv(q[i])) begin
                bad++; $display("FAIL reset_mid cyc%0d outs got=%b exp=%b", i, act(), expv(q[i]));
            end
            advance();
        end
        q.delete();
        rst_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({state_dbg, pc_write, mem_write, ir_write, reg_write} !== 8'b0000_0000) begin
            bad++; $display("FAIL reset_mid_hold got state=%0d pcw=%b mw=%b irw=%b rw=%b exp all 0",
                            state_dbg, pc_write, mem_write, ir_write, reg_write);
        end
        advance();
        rst_n = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({state_dbg, pc_write, mem_write, ir_write, reg_write} !== 8'b0000_0000) begin
            bad++; $display("FAIL reset_mid_release got state=%0d pcw=%b mw=%b irw=%b rw=%b exp all 0",
                            state_dbg, pc_write, mem_write, ir_write, reg_write);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [7];
        int n;
        ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_I;
        ops[4] = OP_BEQ; ops[5] = OP_JAL; ops[6] = OP_BAD;
`ifdef ILLEGAL_OP_TRAP_EN
        n = 6;
`else
        n = 7;
`endif
        for (int k = 0; k < 30; k++)
            build(ops[$urandom_range(0, n - 1)], $urandom_range(0, 2), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)), 0);
        foreach (q[i]) begin
            drive(q[i]);
            total++;
            if (state_dbg !== q[i].st) begin
                bad++; $display("FAIL b2b cyc%0d state got=%0d exp=%0d", i, state_dbg, q[i].st);
            end
            total++;
            if (act() !== expv(q[i])) begin
                bad++; $display("FAIL b2b cyc%0d outs got=%b exp=%b", i, act(), expv(q[i]));
            end
            advance();
        end
        q.delete();
    endtask

    initial begin
        rst_n = 1'b0; op = OP_I; zero = 1'b0; mem_ready = 1'b1;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_sw_jal();
        test_reset_mid();
        test_back_to_back();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
